// File: rtl/register_file.sv
// register_file -- 32-entry architectural register file with rename status
// for an out-of-order core driven by a reorder buffer (ROB).
//
// Each entry holds a 32-bit value, a busy bit and the ROB tag of the
// youngest in-flight producer. The ROB commits values here, and the issue
// stage renames destination registers. x0 is hardwired to zero and is
// never busy.
//
// Optional feature macro: REG_BYPASS_EN
//    defined   : a commit that releases a source register is forwarded to
//                the read ports in the same cycle.
//    undefined : read ports show registered state only. The issue stage is
//                expected to stall one cycle when a commit targets one of
//                its source registers.
//
// Ports
//    clk_in                     system clock, rising edge
//    rst_in                     synchronous active-high reset
//    rdy_in                     global enable; low freezes all state
//    clear_signal               misprediction flush, clears all busy bits
//    reg_done/value/id/tag      ROB commit of one register write
//    issue_signal/issue_rd_id   rename request from the issue stage
//    rob_tag                    ROB entry allocated to the issued instr
//    rs1_id, rs2_id             source register indices
//    rf_value_rsN               source value (combinational)
//    rf_busy_rsN                source still pending in the ROB
//    rf_tag_rsN                 pending ROB tag, valid only when busy

module register_file #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_signal,
   input  logic                 reg_done,
   input  logic [31:0]          reg_value,
   input  logic [4:0]           reg_id,
   input  logic [ROB_WIDTH-1:0] reg_tag,
   input  logic                 issue_signal,
   input  logic [4:0]           issue_rd_id,
   input  logic [ROB_WIDTH-1:0] rob_tag,
   input  logic [4:0]           rs1_id,
   input  logic [4:0]           rs2_id,
   output logic [31:0]          rf_value_rs1,
   output logic [31:0]          rf_value_rs2,
   output logic                 rf_busy_rs1,
   output logic                 rf_busy_rs2,
   output logic [ROB_WIDTH-1:0] rf_tag_rs1,
   output logic [ROB_WIDTH-1:0] rf_tag_rs2
);

   logic [31:0]          r_value [32];
   logic                 r_busy  [32];
   logic [ROB_WIDTH-1:0] r_tag   [32];

   logic w_commit_en;
   logic w_release;
   logic w_rename;

   // A commit always writes its value (x0 excluded). It only releases the
   // rename if the entry is still waiting on exactly this ROB tag; an older
   // producer committing after a newer rename must not clear busy.
   assign w_commit_en = reg_done && (reg_id != 5'd0);
   assign w_release   = w_commit_en && r_busy[reg_id] && (r_tag[reg_id] == reg_tag);
   assign w_rename    = issue_signal && (issue_rd_id != 5'd0);

   // State update. The rename is written after the release so that, when
   // both hit the same register, the later non-blocking assignment keeps
   // the entry busy under the new tag. A flush clears every busy bit and
   // drops the issue, but a simultaneous commit still lands its value.
   // Tags are not reset; they are ignored while busy is clear.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 32; i++) begin
            r_value[i] <= 32'd0;
            r_busy[i]  <= 1'b0;
         end
      end else if (rdy_in) begin
         if (w_commit_en) begin
            r_value[reg_id] <= reg_value;
         end
         if (clear_signal) begin
            for (int i = 0; i < 32; i++) begin
               r_busy[i] <= 1'b0;
            end
         end else begin
            if (w_release) begin
               r_busy[reg_id] <= 1'b0;
            end
            if (w_rename) begin
               r_busy[issue_rd_id] <= 1'b1;
               r_tag[issue_rd_id]  <= rob_tag;
            end
         end
      end
   end

   // Read port 1. x0 is forced to zero / not busy regardless of storage.
   always_comb begin
      rf_value_rs1 = (rs1_id == 5'd0) ? 32'd0 : r_value[rs1_id];
      rf_busy_rs1  = (rs1_id == 5'd0) ? 1'b0  : r_busy[rs1_id];
      rf_tag_rs1   = r_tag[rs1_id];
`ifdef REG_BYPASS_EN
      if (rdy_in && w_release && (reg_id == rs1_id)) begin
         rf_value_rs1 = reg_value;
         rf_busy_rs1  = 1'b0;
      end
`endif
   end

   // Read port 2, identical to port 1.
   always_comb begin
      rf_value_rs2 = (rs2_id == 5'd0) ? 32'd0 : r_value[rs2_id];
      rf_busy_rs2  = (rs2_id == 5'd0) ? 1'b0  : r_busy[rs2_id];
      rf_tag_rs2   = r_tag[rs2_id];
`ifdef REG_BYPASS_EN
      if (rdy_in && w_release && (reg_id == rs2_id)) begin
         rf_value_rs2 = reg_value;
         rf_busy_rs2  = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios followed by randomized
// traffic, all compared against a behavioural array model of the register
// file (value/busy/tag per architectural register).

module tb_register_file;

   localparam int RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, clear_signal, reg_done, issue_signal;
   logic [31:0]   reg_value;
   logic [4:0]    reg_id, issue_rd_id, rs1_id, rs2_id;
   logic [RW-1:0] reg_tag, rob_tag;
   logic [31:0]   rf_value_rs1, rf_value_rs2;
   logic          rf_busy_rs1, rf_busy_rs2;
   logic [RW-1:0] rf_tag_rs1, rf_tag_rs2;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0]   mValue [32];
   logic          mBusy  [32];
   logic [RW-1:0] mTag   [32];

   register_file #(.ROB_WIDTH(RW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .clear_signal(clear_signal), .reg_done(reg_done),
      .reg_value(reg_value), .reg_id(reg_id), .reg_tag(reg_tag),
      .issue_signal(issue_signal), .issue_rd_id(issue_rd_id), .rob_tag(rob_tag),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rf_value_rs1(rf_value_rs1), .rf_value_rs2(rf_value_rs2),
      .rf_busy_rs1(rf_busy_rs1), .rf_busy_rs2(rf_busy_rs2),
      .rf_tag_rs1(rf_tag_rs1), .rf_tag_rs2(rf_tag_rs2)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference behaviour: commit writes value, releases on exact tag match,
   // rename overrides release, flush clears all busy and drops the issue.
   task automatic modelUpdate();
      logic hit;
      if (rst_in) begin
         for (int i = 0; i < 32; i++) begin
            mValue[i] = 0;
            mBusy[i]  = 0;
         end
      end else if (rdy_in) begin
         hit = reg_done && reg_id != 0 && mBusy[reg_id] && mTag[reg_id] == reg_tag;
         if (reg_done && reg_id != 0) mValue[reg_id] = reg_value;
         if (clear_signal) begin
            for (int i = 0; i < 32; i++) mBusy[i] = 0;
         end else begin
            if (hit) mBusy[reg_id] = 0;
            if (issue_signal && issue_rd_id != 0) begin
               mBusy[issue_rd_id] = 1;
               mTag[issue_rd_id]  = rob_tag;
            end
         end
      end
   endtask

   task automatic expectedRead(input logic [4:0] rs, output logic [31:0] v,
                               output logic b, output logic [RW-1:0] t);
      v = (rs == 0) ? 32'd0 : mValue[rs];
      b = (rs == 0) ? 1'b0 : mBusy[rs];
      t = mTag[rs];
`ifdef REG_BYPASS_EN
      if (rdy_in && reg_done && reg_id != 0 && reg_id == rs && mBusy[rs] && mTag[rs] == reg_tag) begin
         v = reg_value;
         b = 1'b0;
      end
`endif
   endtask

   // Compare both read ports against the model (pre-edge state).
   task automatic checkOutput();
      logic [31:0]   v;
      logic          b;
      logic [RW-1:0] t;
      expectedRead(rs1_id, v, b, t);
      checkEq("rs1_value", rf_value_rs1, v);
      checkEq("rs1_busy", {31'd0, rf_busy_rs1}, {31'd0, b});
      if (b) checkEq("rs1_tag", {28'd0, rf_tag_rs1}, {28'd0, t});
      expectedRead(rs2_id, v, b, t);
      checkEq("rs2_value", rf_value_rs2, v);
      checkEq("rs2_busy", {31'd0, rf_busy_rs2}, {31'd0, b});
      if (b) checkEq("rs2_tag", {28'd0, rf_tag_rs2}, {28'd0, t});
   endtask

   task automatic drive(input logic rst, input logic rdy, input logic clr,
                        input logic done, input logic [31:0] val, input logic [4:0] id,
                        input logic [RW-1:0] tg, input logic iss, input logic [4:0] rd,
                        input logic [RW-1:0] rtg, input logic [4:0] r1, input logic [4:0] r2);
      rst_in = rst; rdy_in = rdy; clear_signal = clr;
      reg_done = done; reg_value = val; reg_id = id; reg_tag = tg;
      issue_signal = iss; issue_rd_id = rd; rob_tag = rtg;
      rs1_id = r1; rs2_id = r2;
   endtask

   task automatic clockEdge();
      @(posedge clk_in);
      #1;
      modelUpdate();
      @(negedge clk_in);
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy, input logic clr,
                                input logic done, input logic [31:0] val, input logic [4:0] id,
                                input logic [RW-1:0] tg, input logic iss, input logic [4:0] rd,
                                input logic [RW-1:0] rtg, input logic [4:0] r1, input logic [4:0] r2);
      drive(rst, rdy, clr, done, val, id, tg, iss, rd, rtg, r1, r2);
      #1;
      checkOutput();
      clockEdge();
   endtask

   // Idle inputs, read one register on both ports and compare to constants.
   task automatic expectReg(input string name, input logic [4:0] id, input logic [31:0] val,
                            input logic busy, input logic chkTag, input logic [RW-1:0] tg);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, id, id);
      #1;
      checkEq({name, "_value"}, rf_value_rs1, val);
      checkEq({name, "_busy"}, {31'd0, rf_busy_rs1}, {31'd0, busy});
      if (chkTag) checkEq({name, "_tag"}, {28'd0, rf_tag_rs1}, {28'd0, tg});
      checkEq({name, "_value2"}, rf_value_rs2, val);
      checkEq({name, "_busy2"}, {31'd0, rf_busy_rs2}, {31'd0, busy});
      @(negedge clk_in);
   endtask

   initial begin
      logic [4:0]    id;
      logic [RW-1:0] tg;

      for (int i = 0; i < 32; i++) begin
         mValue[i] = 0; mBusy[i] = 0; mTag[i] = 0;
      end

      // Reset for two cycles; DUT state is unknown before this, so no checks.
      drive(1, 1, 1, 1, 32'h1234, 5'd1, 0, 1, 5'd2, 0, 0, 0);
      repeat (2) @(posedge clk_in);
      #1;
      modelUpdate();
      @(negedge clk_in);

      // Every register reads zero, not busy, after reset.
      for (int i = 1; i < 32; i++) expectReg("reset", i[4:0], 32'd0, 1'b0, 1'b0, 0);

      // Rename then matching commit releases the entry.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd5, 4'd3, 5'd5, 5'd0);
      expectReg("renamed_x5", 5'd5, 32'd0, 1'b1, 1'b1, 4'd3);
      applyStimulus(0, 1, 0, 1, 32'hDEADBEEF, 5'd5, 4'd3, 0, 0, 0, 5'd5, 5'd1);
      expectReg("commit_x5", 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 0);

      // Stale-tag commit writes the value but keeps the newer rename.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd7, 4'd2, 5'd7, 5'd7);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd7, 4'd6, 5'd7, 5'd7);
      applyStimulus(0, 1, 0, 1, 32'h11, 5'd7, 4'd2, 0, 0, 0, 5'd7, 5'd7);
      expectReg("stale_x7", 5'd7, 32'h11, 1'b1, 1'b1, 4'd6);

      // Same-cycle commit and rename of one register: rename wins.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd9, 4'd4, 5'd9, 5'd0);
      applyStimulus(0, 1, 0, 1, 32'h55, 5'd9, 4'd4, 1, 5'd9, 4'd8, 5'd9, 5'd9);
      expectReg("both_x9", 5'd9, 32'h55, 1'b1, 1'b1, 4'd8);

      // Flush with simultaneous commit and issue.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd3, 4'd1, 5'd3, 5'd4);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd4, 4'd2, 5'd3, 5'd4);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd10, 4'd5, 5'd10, 5'd4);
      applyStimulus(0, 1, 1, 1, 32'h77, 5'd4, 4'd2, 1, 5'd11, 4'd9, 5'd3, 5'd10);
      expectReg("flush_x3", 5'd3, 32'd0, 1'b0, 1'b0, 0);
      expectReg("flush_x4", 5'd4, 32'h77, 1'b0, 1'b0, 0);
      expectReg("flush_x10", 5'd10, 32'd0, 1'b0, 1'b0, 0);
      expectReg("flush_x11", 5'd11, 32'd0, 1'b0, 1'b0, 0);
      expectReg("flush_x7", 5'd7, 32'h11, 1'b0, 1'b0, 0);

      // Same-cycle forwarding of a releasing commit.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 5'd12, 4'd1, 5'd12, 5'd0);
      drive(0, 1, 0, 1, 32'hABCD, 5'd12, 4'd1, 0, 0, 0, 5'd12, 5'd12);
      #1;
      checkOutput();
`ifdef REG_BYPASS_EN
      checkEq("bypass_value", rf_value_rs1, 32'hABCD);
      checkEq("bypass_busy", {31'd0, rf_busy_rs1}, 32'd0);
`else
      checkEq("nobypass_value", rf_value_rs1, 32'd0);
      checkEq("nobypass_busy", {31'd0, rf_busy_rs1}, 32'd1);
`endif
      clockEdge();
      expectReg("after_x12", 5'd12, 32'hABCD, 1'b0, 1'b0, 0);

      // x0 ignores commits and renames.
      applyStimulus(0, 1, 0, 1, 32'd5, 5'd0, 4'd0, 1, 5'd0, 4'd3, 5'd0, 5'd0);
      expectReg("x0", 5'd0, 32'd0, 1'b0, 1'b0, 0);

      // rdy_in low loses every event.
      applyStimulus(0, 0, 0, 1, 32'h1, 5'd5, 4'd0, 1, 5'd13, 4'd3, 5'd5, 5'd13);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
      expectReg("hold_x5", 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 0);
      expectReg("hold_x13", 5'd13, 32'd0, 1'b0, 1'b0, 0);

      // Reset overrides simultaneous flush/commit/issue.
      applyStimulus(1, 1, 1, 1, 32'h99, 5'd6, 4'd0, 1, 5'd6, 4'd2, 5'd6, 5'd5);
      expectReg("rst_x6", 5'd6, 32'd0, 1'b0, 1'b0, 0);
      expectReg("rst_x5", 5'd5, 32'd0, 1'b0, 1'b0, 0);

      // Randomized traffic on a small register window so tags often match.
      for (int n = 0; n < 600; n++) begin
         id = 5'($urandom_range(0, 7));
         tg = ($urandom_range(0, 2) != 0) ? mTag[id] : RW'($urandom);
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 11) == 0),
                       1'($urandom),
                       $urandom,
                       id,
                       tg,
                       1'($urandom),
                       5'($urandom_range(0, 7)),
                       RW'($urandom),
                       ($urandom_range(0, 2) == 0) ? id : 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 2) == 0) ? id : 5'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
